// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic inter-stage pipeline register with stall, flush and stall-cycle counter
module pipe_stage_reg #(
    parameter int          DATA_W    = 160,
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              flush_keep_pc_i,
    input  logic              valid_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              bubble_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // data_i is only sampled on a load, so an unknown payload during stall/flush never reaches data_o
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o     <= 1'b0;
            instr_o     <= NOP_INSTR;
            pc_o        <= PC_RESET;
            data_o      <= '0;
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            valid_o     <= 1'b0;
            instr_o     <= NOP_INSTR;
            pc_o        <= flush_keep_pc_i ? pc_i : PC_RESET;
            data_o      <= '0;
            stall_cnt_o <= '0;
        end else if (stall_i) begin
            if (stall_cnt_o != CNT_MAX) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end else begin
            valid_o     <= valid_i;
            instr_o     <= instr_i;
            pc_o        <= pc_i;
            data_o      <= data_i;
            stall_cnt_o <= '0;
        end
    end

    assign bubble_o = ~valid_o;

endmodule
